// File: rtl/cpu_seq_pkg.sv
// Shared types for the NPC multi-cycle stage sequencer.
// Used by cpu_stage_seq and seq_tmo_cnt.
package cpu_seq_pkg;

    localparam int TMO_W_DEF = 8;

    typedef enum logic [3:0] {
        RST      = 4'd0,
        IF_REQ   = 4'd1,
        IF_WAIT  = 4'd2,
        EX       = 4'd3,
        MEM_REQ  = 4'd4,
        MEM_WAIT = 4'd5,
        WB       = 4'd6,
        HALT     = 4'd7,
        ERR      = 4'd8
    } seq_state_t;

    typedef struct packed {
        logic reg_wr;
        logic mem_to_reg;
        logic mem_wr;
    } dec_ctl_t;

    // States where the sequencer is waiting on a memory port.
    function automatic logic is_bus_wait(input seq_state_t s);
        return s inside {IF_REQ, IF_WAIT, MEM_REQ, MEM_WAIT};
    endfunction

endpackage

// File: rtl/seq_tmo_cnt.sv
// Bus-timeout counter: clears on state change, counts while enabled.
// sat flags the cycle whose edge brings the count to all-ones.
module seq_tmo_cnt
    import cpu_seq_pkg::*;
#(
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic sat
);

    localparam logic [TMO_W-1:0] ONES = '1;
    localparam logic [TMO_W-1:0] LAST = ~(TMO_W'(1));

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != ONES) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    // Independent of clr so the FSM can use it to pick the next state.
    assign sat = en & (cnt_q == LAST);

endmodule

// File: rtl/cpu_stage_seq.sv
// Multi-cycle IF/EX/MEM/WB sequencer with IFU/LSU valid/ready handshakes.
// Define SEQ_PERF_EN to add perf_cycle/perf_instret counters.
module cpu_stage_seq
    import cpu_seq_pkg::*;
#(
    parameter int TMO_W      = TMO_W_DEF,
    parameter int MEM_EX_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_ready,
    output logic        inst_latch_en,
    input  logic        dec_RegWr,
    input  logic        dec_MemtoReg,
    input  logic        dec_MemWr,
    output logic        lsu_req_valid,
    output logic        lsu_req_wen,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        lsu_rsp_ready,
    output logic        rf_wen,
    output logic        pc_wen,
    input  logic        halt_req,
    output logic        halted,
    output logic        bus_err
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0] perf_cycle,
    output logic [31:0] perf_instret
`endif
);

    localparam logic [1:0] EX_LAST = 2'(MEM_EX_CYC - 1);

    seq_state_t state_q;
    seq_state_t state_d;
    logic [1:0] ex_cnt_q;
    logic       ex_last;
    logic       wen_q;
    logic       tmo_en;
    logic       tmo_clr;
    logic       tmo_sat;
    dec_ctl_t   dec;

    assign dec = '{
        reg_wr:     dec_RegWr,
        mem_to_reg: dec_MemtoReg,
        mem_wr:     dec_MemWr
    };

    assign ex_last = (ex_cnt_q == EX_LAST);
    assign tmo_en  = is_bus_wait(state_q);
    assign tmo_clr = (state_d != state_q);

    seq_tmo_cnt #(
        .TMO_W(TMO_W)
    ) u_tmo (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tmo_clr),
        .en   (tmo_en),
        .sat  (tmo_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_cnt_q <= 2'd0;
        end else if (state_q == EX && !ex_last) begin
            ex_cnt_q <= ex_cnt_q + 2'd1;
        end else begin
            ex_cnt_q <= 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q <= 1'b0;
        end else if (state_q == EX && state_d == MEM_REQ) begin
            wen_q <= dec.mem_wr;
        end
    end

    always_comb begin
        state_d       = state_q;
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        inst_latch_en = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_req_wen   = 1'b0;
        lsu_rsp_ready = 1'b0;
        rf_wen        = 1'b0;
        pc_wen        = 1'b0;
        halted        = 1'b0;
        bus_err       = 1'b0;
        unique case (state_q)
            RST: state_d = IF_REQ;
            IF_REQ: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) begin
                    state_d = IF_WAIT;
                end else if (tmo_sat) begin
                    state_d = ERR;
                end
            end
            IF_WAIT: begin
                ifu_rsp_ready = 1'b1;
                if (ifu_rsp_valid) begin
                    inst_latch_en = 1'b1;
                    state_d       = EX;
                end else if (tmo_sat) begin
                    state_d = ERR;
                end
            end
            EX: begin
                // Halt wins over any memory or writeback exit.
                if (ex_last) begin
                    if (halt_req) begin
                        state_d = HALT;
                    end else if (dec.mem_to_reg | dec.mem_wr) begin
                        state_d = MEM_REQ;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            MEM_REQ: begin
                lsu_req_valid = 1'b1;
                lsu_req_wen   = wen_q;
                if (lsu_req_ready) begin
                    state_d = MEM_WAIT;
                end else if (tmo_sat) begin
                    state_d = ERR;
                end
            end
            MEM_WAIT: begin
                lsu_rsp_ready = 1'b1;
                if (lsu_rsp_valid) begin
                    state_d = WB;
                end else if (tmo_sat) begin
                    state_d = ERR;
                end
            end
            WB: begin
                pc_wen  = 1'b1;
                rf_wen  = dec.reg_wr & ~dec.mem_wr;
                state_d = IF_REQ;
            end
            HALT: halted  = 1'b1;
            ERR:  bus_err = 1'b1;
            default: state_d = ERR;
        endcase
    end

`ifdef SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycle   <= 32'd0;
            perf_instret <= 32'd0;
        end else begin
            if (state_q != HALT && state_q != ERR) begin
                perf_cycle <= perf_cycle + 32'd1;
            end
            if (state_q == WB) begin
                perf_instret <= perf_instret + 32'd1;
            end
        end
    end
`endif

endmodule
